// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding, client IDs and default widths for mem_arbiter.
package mem_arb_pkg;
    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;
    localparam logic CLI_I = 1'b0;
    localparam logic CLI_D = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for mem_arbiter.
// MEM_ARB_RR_EN defined: a tie goes to the client that was not granted last; otherwise D wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    logic tie_d;
`ifdef MEM_ARB_RR_EN
    assign tie_d = (last_grant != CLI_D);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_d = 1'b1;
`endif
    assign grant_valid = i_req | d_req;
    assign grant = (d_req & (~i_req | tie_d)) ? CLI_D : CLI_I;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory port between the I-cache and D-cache.
// Tie-break policy is selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::MEM_DATA_W
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import mem_arb_pkg::*;
    arb_state_t state, state_nxt;
    logic last_grant, win_valid, win, i_req, d_req;
    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
    mem_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (win_valid),
        .grant       (win)
    );
    // A simultaneous read+write is illegal; the write takes precedence.
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state)
            IDLE: state_nxt = win_valid ? ((win == CLI_D) ? GRANT_D : GRANT_I) : IDLE;
            GRANT_I: begin
                mem_write = i_write;
                mem_read  = i_read & ~i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
                state_nxt = mem_ready ? RELEASE : GRANT_I;
            end
            GRANT_D: begin
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
                state_nxt = mem_ready ? RELEASE : GRANT_D;
            end
            RELEASE: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state      <= IDLE;
            last_grant <= CLI_I;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_valid) last_grant <= win;
            if (i_ready && mem_read) i_rdata <= mem_rdata;
            if (d_ready && mem_read) d_rdata <= mem_rdata;
        end
    end
endmodule
